ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 command transmitter; the send direction paired with the mouse receiver.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 command transmitter (the send half of the mouse /
//   keyboard link). A command byte is sent with the PS/2 request-to-send
//   sequence: inhibit the clock, pull data low, release the clock, then put
//   8 data bits (LSB first), odd parity and stop on the device-generated
//   clock. The device acknowledge is captured on the 11th falling edge.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active high
//   tx_data   in   command byte, sampled only when the byte is accepted
//   tx_valid  in   request to send tx_data
//   tx_ready  out  high in IDLE; accept = tx_valid & tx_ready on a clk edge
//   done      out  one-cycle pulse when a transfer ends (ack or error)
//   ack_err   out  1 = no device ack (or timeout); held until next accept
//   msclk_in  in   PS/2 clock pin level (asynchronous)
//   msdat_in  in   PS/2 data pin level (asynchronous)
//   msclk_oe  out  1 = pull msclk low (open drain)
//   msdat_oe  out  1 = pull msdat low (open drain)
//
// Parameters
//   INHIBIT_CYCLES  clk cycles msclk is held low before the RTS cycle
//   TIMEOUT_CYCLES  watchdog limit per device clock edge
//
// Configuration
//   PS2TX_TIMEOUT_EN  when defined, a watchdog aborts the transfer with
//                     ack_err=1 if the device stops clocking. Without it the
//                     FSM waits indefinitely and only rst recovers.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_err,
  input  logic       msclk_in,
  input  logic       msdat_in,
  output logic       msclk_oe,
  output logic       msdat_oe
);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam int              CNT_W        = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shreg;
  logic [3:0]       bitcnt;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_prev;
  logic             fe;
  logic             accept;
  logic             wd_expired;

  // -------------------------------------------------------------------------
  // Pin synchronisers and falling-edge detect on the device clock. The
  // synchronisers reset to the idle (released, high) bus level.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage read the previous
      // cycle's value, which is exactly what a synchroniser chain needs.
      clk_sync <= {clk_sync[0], msclk_in};
      dat_sync <= {dat_sync[0], msdat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign fe       = clk_prev & ~clk_sync[1];
  assign tx_ready = (state == ST_IDLE);
  assign accept   = tx_valid & tx_ready;
  assign done     = (state == ST_DONE);

  // -------------------------------------------------------------------------
  // Optional watchdog: restarts on every device falling edge and on every
  // state change, counts only while the device is expected to clock.
  // -------------------------------------------------------------------------
`ifdef PS2TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            wd_active;

  assign wd_active  = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign wd_expired = wd_active && !fe && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !wd_active || fe || (state_next != state)) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WD_W'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting state_next before the case keeps every path assigned,
    // so no latch is inferred for the "stay" branches.
    state_next = state;
    case (state)
      ST_IDLE:      if (accept) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (cnt == INHIBIT_LAST) state_next = ST_RTS;
      ST_RTS:       state_next = ST_SHIFT;
      // The 10th falling edge puts the stop bit (data released) on the bus.
      ST_SHIFT:     if (fe && (bitcnt == 4'd9)) state_next = ST_ACK;
      ST_ACK:       if (fe) state_next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (clk_sync[1] && dat_sync[1]) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
    if (wd_expired) state_next = ST_DONE;
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      ack_err <= 1'b0;
      // NOTE: shreg is deliberately left out of reset; it is always loaded on
      // accept before it can reach msdat_oe.
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt     <= '0;
            bitcnt  <= '0;
            ack_err <= 1'b0;
            shreg   <= {1'b1, ~^tx_data, tx_data};
          end
        end
        ST_INHIBIT: cnt <= cnt + CNT_W'(1);
        ST_SHIFT: begin
          if (fe) begin
            bitcnt <= bitcnt + 4'd1;
            // The start bit is not held in shreg: fe1 only exposes d0, and
            // each later edge advances to the next bit.
            if (bitcnt != 4'd0) shreg <= {1'b0, shreg[9:1]};
          end
        end
        ST_ACK: if (fe) ack_err <= dat_sync[1];
        default: ;
      endcase
      if (wd_expired) ack_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Open-drain enables
  // -------------------------------------------------------------------------
  assign msclk_oe = (state == ST_INHIBIT) || (state == ST_RTS);
  assign msdat_oe = (state == ST_RTS) ||
                    ((state == ST_SHIFT) && ((bitcnt == 4'd0) || !shreg[0]));

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Self-checking bench for ps2_host_tx. A behavioural PS/2 device shares the
//   open-drain bus with the DUT, generates the device clock, samples data on
//   the rising edge and optionally acknowledges. Frames the device collects
//   are compared against the PS/2 frame computed from the byte sent.
//   The device clock is scaled to 2*HALF clk cycles to keep runs short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 16;
  localparam int TO   = 100;
  localparam int HALF = 20;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       done;
  logic       ack_err;
  logic       msclk_oe;
  logic       msdat_oe;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  msclk = ~(msclk_oe | dev_clk_low);
  wire  msdat = ~(msdat_oe | dev_dat_low);

  int checks   = 0;
  int failures = 0;

  int   done_cnt     = 0;
  int   accept_cnt   = 0;
  logic last_ack_err = 1'b0;

  int oe_run = 0, oe_both = 0, oe_both_at = 0;
  int last_run = 0, last_both = 0, last_both_at = 0;

  int          base;
  int          t5_base;
  logic [10:0] seen;
  logic [7:0]  d;
  bit          a;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .done    (done),
    .ack_err (ack_err),
    .msclk_in(msclk),
    .msdat_in(msdat),
    .msclk_oe(msclk_oe),
    .msdat_oe(msdat_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Frame as seen by the device: [0]=start, [8:1]=data LSB first, [9]=odd
  // parity, [10]=stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0), b, 1'b0};
  endfunction

  // Monitors: done pulses, accepts, and the length of each msclk_oe run.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt     <= done_cnt + 1;
      last_ack_err <= ack_err;
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) accept_cnt <= accept_cnt + 1;
  end

  always @(negedge clk) begin
    if (msclk_oe === 1'b1) begin
      oe_run <= oe_run + 1;
      if (msdat_oe === 1'b1) begin
        oe_both    <= oe_both + 1;
        oe_both_at <= oe_run + 1;
      end
    end else if (oe_run != 0) begin
      last_run     <= oe_run;
      last_both    <= oe_both;
      last_both_at <= oe_both_at;
      oe_run       <= 0;
      oe_both      <= 0;
      oe_both_at   <= 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Behavioural device. abort_fe != 0 returns with the device clock held low
  // right after that falling edge.
  task automatic dev_frame(input bit give_ack, input int abort_fe, output logic [10:0] got);
    int w = 0;
    got = '1;
    while (msclk !== 1'b0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    while (!(msclk === 1'b1 && msdat === 1'b0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("rts_seen", {30'd0, msclk, msdat}, 32'h2);
    if (!(msclk === 1'b1 && msdat === 1'b0)) return;
    got[0] = msdat;
    cyc(2);
    check("inhibit_len", last_run, INH + 1);
    check("rts_len", last_both, 1);
    check("rts_pos", last_both_at, INH + 1);
    cyc(HALF - 2);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      if (k == abort_fe) return;
      dev_clk_low = 1'b0;
      got[k] = msdat;
      cyc(HALF);
    end
    dev_dat_low = give_ack;
    cyc(2);
    dev_clk_low = 1'b1;
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(2);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int b, input logic exp_ack, input string tag);
    int w = 0;
    while (done_cnt == b && w < 3000) begin
      @(negedge clk);
      w++;
    end
    cyc(5);
    check({tag, "_done_once"}, done_cnt - b, 1);
    check({tag, "_ack_err"}, {31'd0, last_ack_err}, {31'd0, exp_ack});
    check({tag, "_ack_hold"}, {31'd0, ack_err}, {31'd0, exp_ack});
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_clk_oe", {31'd0, msclk_oe}, 0);
    check("rst_dat_oe", {31'd0, msdat_oe}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ack_err", {31'd0, ack_err}, 0);
    rst = 1'b0;
    cyc(2);
    check("rst_ready", {31'd0, tx_ready}, 1);

    // 1. 0xF4 with device ack
    base = done_cnt;
    send(8'hF4);
    dev_frame(1'b1, 0, seen);
    check("f4_frame", seen, frame_of(8'hF4));
    wait_done(base, 1'b0, "f4");

    // 2. 0xFF, device never acks
    base = done_cnt;
    send(8'hFF);
    dev_frame(1'b0, 0, seen);
    check("ff_frame", seen, frame_of(8'hFF));
    check("ff_parity", {31'd0, seen[9]}, 1);
    wait_done(base, 1'b1, "ff");

    // 3. 0x00 (inhibit length is checked inside every frame)
    base = done_cnt;
    send(8'h00);
    dev_frame(1'b1, 0, seen);
    check("z_frame", seen, frame_of(8'h00));
    check("z_parity", {31'd0, seen[9]}, 1);
    wait_done(base, 1'b0, "z");

    // 4. Reset after the 4th device falling edge, then a clean 0xAA
    base = done_cnt;
    send(8'h5A);
    dev_frame(1'b1, 4, seen);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_clk_oe", {31'd0, msclk_oe}, 0);
    check("abort_dat_oe", {31'd0, msdat_oe}, 0);
    check("abort_ready", {31'd0, tx_ready}, 1);
    check("abort_done", {31'd0, done}, 0);
    check("abort_ack_err", {31'd0, ack_err}, 0);
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(200);
    check("abort_no_done", done_cnt - base, 0);
    base = done_cnt;
    send(8'hAA);
    dev_frame(1'b1, 0, seen);
    check("aa_frame", seen, frame_of(8'hAA));
    wait_done(base, 1'b0, "aa");

    // 5. tx_valid held across a transfer: second byte goes only after done
    base    = done_cnt;
    t5_base = accept_cnt;
    @(negedge clk);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    fork
      begin
        int w;
        w = 0;
        while (accept_cnt < t5_base + 1 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        tx_data = 8'h34;
        while (accept_cnt < t5_base + 2 && w < 10000) begin
          @(negedge clk);
          w++;
        end
        tx_valid = 1'b0;
      end
    join_none
    dev_frame(1'b1, 0, seen);
    check("hold_first", seen, frame_of(8'h12));
    dev_frame(1'b1, 0, seen);
    check("hold_second", seen, frame_of(8'h34));
    cyc(100);
    check("hold_done_pulses", done_cnt - base, 2);
    check("hold_accepts", accept_cnt - t5_base, 2);

    // Randomised frames
    for (int i = 0; i < 10; i++) begin
      d    = 8'($urandom_range(0, 255));
      a    = 1'($urandom_range(0, 1));
      base = done_cnt;
      send(d);
      dev_frame(a, 0, seen);
      check($sformatf("rnd%0d_frame", i), seen, frame_of(d));
      wait_done(base, !a, $sformatf("rnd%0d", i));
    end

`ifdef PS2TX_TIMEOUT_EN
    // 6. Device never clocks: watchdog ends the transfer
    begin
      int w;
      int n;
      w = 0;
      n = 0;
      send(8'hF4);
      while (msclk_oe === 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      while (done !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("to_latency_ok", {31'd0, (n >= TO - 1) && (n <= TO + 1)}, 1);
      check("to_done", {31'd0, done}, 1);
      check("to_ack_err", {31'd0, ack_err}, 1);
      check("to_clk_oe", {31'd0, msclk_oe}, 0);
      check("to_dat_oe", {31'd0, msdat_oe}, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
